// File: rtl/bfm_apbslave_mem_pkg.sv
// Shared types and constants for the APB slave memory model.
package apb_bfm_pkg;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  // The address is illegal if it lies past the end of memory or is not word aligned.
  function automatic logic addr_error(input logic [APB_AW-1:0] addr,
                                      input logic [APB_AW-1:0] limit);
    return (addr >= limit) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/bfm_apbslave_mem_if.sv
// APB3 bus bundle between the BFM master and the slave memory model.
// PSTRB exists only when APB4_PSTRB_EN is defined.
interface bfm_apbslave_mem_if;
  import apb_bfm_pkg::*;

  logic              PSEL;
  logic [APB_AW-1:0] PADDR;
  logic              PENABLE;
  logic              PWRITE;
  logic [APB_DW-1:0] PWDATA;
`ifdef APB4_PSTRB_EN
  logic [3:0]        PSTRB;
`endif
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

`ifdef APB4_PSTRB_EN
  modport master (output PSEL, PADDR, PENABLE, PWRITE, PWDATA, PSTRB,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PADDR, PENABLE, PWRITE, PWDATA, PSTRB,
                  output PRDATA, PREADY, PSLVERR);
`else
  modport master (output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
`endif

endinterface

// File: rtl/bfm_apbslave_mem_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a registered read port.
// Contents are intentionally not reset.
module bfm_apbslave_ram #(
  parameter int WORDS = 256,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] waddr,
  input  logic [3:0]       wbe,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [WORDS];

  // Byte-lane writes and a read that is re-registered every cycle.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/bfm_apbslave_mem.sv
// APB3 completer model backed by a RAM, with programmable wait states,
// error responses on bad addresses and sticky abort detection.
// Optional byte strobes: define APB4_PSTRB_EN.
//
//  state  | meaning
//  IDLE   | waiting for a setup phase (PSEL=1, PENABLE=0)
//  ACCESS | transfer latched; counting wait states, then PREADY until PENABLE completes it
module bfm_apbslave_mem
  import apb_bfm_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int WAIT_W    = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  bfm_apbslave_mem_if.slave apb,
  input  logic [WAIT_W-1:0] WAIT_STATES,
  output logic [15:0]       XFER_COUNT,
  output logic              ABORT_SEEN
);

  localparam int                IDX_W      = $clog2(MEM_WORDS);
  localparam logic [APB_AW-1:0] BYTE_LIMIT = APB_AW'(MEM_WORDS * 4);

  apb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [APB_DW-1:0] wdata_q, wdata_d;
  logic [3:0]        strb_q, strb_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic              rd_ok_q, rd_ok_d;
  logic [15:0]       xfer_q, xfer_d;
  logic              abort_q, abort_d;
  logic [3:0]        ram_wbe;
  logic [IDX_W-1:0]  ram_raddr;
  logic [31:0]       ram_rdata;
  logic              setup_err;
  logic [3:0]        setup_strb;

  assign setup_err = addr_error(apb.PADDR, BYTE_LIMIT);
`ifdef APB4_PSTRB_EN
  assign setup_strb = apb.PSTRB;
`else
  assign setup_strb = 4'hF;
`endif

  // Reading straight from PADDR in IDLE lets a zero-wait read have data in T1.
  assign ram_raddr = (state_q == IDLE) ? apb.PADDR[IDX_W+1:2] : idx_q;

  bfm_apbslave_ram #(.WORDS(MEM_WORDS), .IDX_W(IDX_W)) u_ram (
    .clk   (PCLK),
    .waddr (idx_q),
    .wbe   (ram_wbe),
    .wdata (wdata_q),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // State and datapath registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      rd_ok_q   <= 1'b0;
      xfer_q    <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      write_q   <= write_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      rd_ok_q   <= rd_ok_d;
      xfer_q    <= xfer_d;
      abort_q   <= abort_d;
    end
  end

  // Next-state, wait countdown, completion and abort handling.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    write_d   = write_q;
    err_d     = err_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    rd_ok_d   = rd_ok_q;
    xfer_d    = xfer_q;
    abort_d   = abort_q;
    ram_wbe   = '0;
    case (state_q)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          state_d = ACCESS;
          idx_d   = apb.PADDR[IDX_W+1:2];
          wdata_d = apb.PWDATA;
          write_d = apb.PWRITE;
          strb_d  = setup_strb;
          err_d   = setup_err;
          wcnt_d  = WAIT_STATES;
          if (WAIT_STATES == '0) begin
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            rd_ok_d   = !apb.PWRITE && !setup_err;
          end
        end
      end
      ACCESS: begin
        if (!apb.PSEL) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          rd_ok_d   = 1'b0;
          abort_d   = 1'b1;
        end else if (pready_q) begin
          if (apb.PENABLE) begin
            if (write_q && !err_q) ram_wbe = strb_q;
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            rd_ok_d   = 1'b0;
            xfer_d    = xfer_q + 16'd1;
          end
        end else if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q == WAIT_W'(1)) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            rd_ok_d   = !write_q && !err_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = rd_ok_q ? ram_rdata : '0;
  assign XFER_COUNT  = xfer_q;
  assign ABORT_SEEN  = abort_q;

endmodule

// File: tb/tb_bfm_apbslave_mem.sv
// Self-checking bench for bfm_apbslave_mem: directed scenarios plus randomized
// transfers, compared every cycle against a transaction-level memory model.
module tb_bfm_apbslave_mem;

  logic        clk = 1'b0;
  logic        PRESET;
  logic [3:0]  WAIT_STATES;
  logic [15:0] XFER_COUNT;
  logic        ABORT_SEEN;

  bfm_apbslave_mem_if bus ();

  bfm_apbslave_mem #(.MEM_WORDS(256), .WAIT_W(4)) dut (
    .PCLK        (clk),
    .PRESET      (PRESET),
    .apb         (bus),
    .WAIT_STATES (WAIT_STATES),
    .XFER_COUNT  (XFER_COUNT),
    .ABORT_SEEN  (ABORT_SEEN)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model state
  logic [31:0] mdl_mem   [256];
  logic [3:0]  mdl_known [256];
  logic        exp_pready, exp_pslverr, exp_rd_known, chk_en;
  logic [31:0] exp_prdata;
  logic [15:0] exp_xfer;
  logic        exp_abort;

  // captured results of the last transfer
  int          cap_k;
  logic [31:0] cap_prdata;
  logic        cap_pslverr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle_exp();
    exp_pready   = 1'b0;
    exp_pslverr  = 1'b0;
    exp_prdata   = '0;
    exp_rd_known = 1'b1;
  endtask

  task automatic bus_idle();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("PREADY", {31'b0, bus.PREADY}, {31'b0, exp_pready});
      chk("PSLVERR", {31'b0, bus.PSLVERR}, {31'b0, exp_pslverr});
      if (exp_rd_known) chk("PRDATA", bus.PRDATA, exp_prdata);
      chk("XFER_COUNT", {16'b0, XFER_COUNT}, {16'b0, exp_xfer});
      chk("ABORT_SEEN", {31'b0, ABORT_SEEN}, {31'b0, exp_abort});
    end
  end

  // One APB transfer starting now (called at posedge+1). mode: 0 normal,
  // 1 drop PSEL in access cycle 'at', 2 assert PRESET in access cycle 'at'.
  // Returns at posedge+1 of the cycle after the transfer with the bus idle.
  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input int ws, input logic [3:0] strb, input int mode, input int at);
    bit          err;
    bit          cut;
    int          idx;
    logic [3:0]  eff;
    logic [31:0] a;
    a   = addr;
    err = (a >= 32'd1024) || (a[1:0] != 2'b00);
    idx = int'(a[9:2]);
`ifdef APB4_PSTRB_EN
    eff = strb;
`else
    eff = 4'hF | strb;
`endif
    cut = 1'b0;
    cap_k = 0; cap_prdata = '0; cap_pslverr = 1'b0;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = a; bus.PWRITE = wr;
    bus.PWDATA = data; WAIT_STATES = 4'(ws);
`ifdef APB4_PSTRB_EN
    bus.PSTRB = strb;
`endif
    set_idle_exp();
    for (int k = 1; k <= ws + 1; k++) begin
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      bus.PADDR   = $urandom;
      bus.PWDATA  = $urandom;
      WAIT_STATES = 4'($urandom);
      set_idle_exp();
      if (k == ws + 1) begin
        exp_pready  = 1'b1;
        exp_pslverr = err;
        if (!wr && !err) begin
          exp_prdata   = mdl_mem[idx];
          exp_rd_known = (mdl_known[idx] == 4'hF);
        end
      end
      if (bus.PREADY && cap_k == 0) begin
        cap_k = k; cap_prdata = bus.PRDATA; cap_pslverr = bus.PSLVERR;
      end
      if (mode != 0 && k == at) begin
        if (mode == 1) bus_idle();
        else PRESET = 1'b1;
        cut = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!cut) begin
      exp_xfer = exp_xfer + 16'd1;
      if (wr && !err) begin
        for (int b = 0; b < 4; b++) begin
          if (eff[b]) begin
            mdl_mem[idx][8*b +: 8] = data[8*b +: 8];
            mdl_known[idx][b] = 1'b1;
          end
        end
      end
    end else if (mode == 1) begin
      exp_abort = 1'b1;
    end else begin
      PRESET    = 1'b0;
      exp_xfer  = '0;
      exp_abort = 1'b0;
    end
    bus_idle();
    set_idle_exp();
  endtask

  logic [15:0] saved_cnt;
  logic [31:0] r_addr;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mdl_mem[i] = '0;
      mdl_known[i] = 4'h0;
    end
    chk_en = 1'b0;
    exp_xfer = '0; exp_abort = 1'b0;
    set_idle_exp();
    PRESET = 1'b1;
    WAIT_STATES = '0;
    bus.PADDR = '0; bus.PWRITE = 1'b0; bus.PWDATA = '0;
`ifdef APB4_PSTRB_EN
    bus.PSTRB = 4'hF;
`endif
    bus_idle();
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("reset_xfer", {16'b0, XFER_COUNT}, 32'd0);
    @(posedge clk); #1;
    PRESET = 1'b0;

    // zero-wait write then read
    do_xfer(1, 32'h10, 32'hDEADBEEF, 0, 4'hF, 0, 0);
    chk("t1_wr_latency", cap_k, 1);
    do_xfer(0, 32'h10, 32'h0, 0, 4'hF, 0, 0);
    chk("t1_rd_latency", cap_k, 1);
    chk("t1_rdata", cap_prdata, 32'hDEADBEEF);
    chk("t1_pslverr", {31'b0, cap_pslverr}, 32'd0);
    chk("t1_count", {16'b0, XFER_COUNT}, 32'd2);

    // three wait states
    do_xfer(0, 32'h10, 32'h0, 3, 4'hF, 0, 0);
    chk("t2_latency", cap_k, 4);
    chk("t2_rdata", cap_prdata, 32'hDEADBEEF);
    chk("t2_rdata_after", bus.PRDATA, 32'h0);

    // error responses: first out-of-range byte and misaligned
    do_xfer(1, 32'd1024, 32'h12345678, 1, 4'hF, 0, 0);
    chk("t3_err_range", {31'b0, cap_pslverr}, 32'd1);
    do_xfer(1, 32'h13, 32'h87654321, 0, 4'hF, 0, 0);
    chk("t3_err_align", {31'b0, cap_pslverr}, 32'd1);
    do_xfer(1, 32'd1020, 32'hCAFE0001, 0, 4'hF, 0, 0);
    chk("t3_last_word_ok", {31'b0, cap_pslverr}, 32'd0);
    do_xfer(0, 32'h10, 32'h0, 0, 4'hF, 0, 0);
    chk("t3_rdata", cap_prdata, 32'hDEADBEEF);

    // abort after one access cycle
    do_xfer(1, 32'h20, 32'hA5A50020, 0, 4'hF, 0, 0);
    saved_cnt = XFER_COUNT;
    do_xfer(1, 32'h20, 32'h00000001, 5, 4'hF, 1, 2);
    chk("t4_abort", {31'b0, ABORT_SEEN}, 32'd1);
    chk("t4_count", {16'b0, XFER_COUNT}, {16'b0, saved_cnt});
    do_xfer(0, 32'h20, 32'h0, 0, 4'hF, 0, 0);
    chk("t4_mem", cap_prdata, 32'hA5A50020);

    // reset during wait states of a write
    do_xfer(1, 32'h30, 32'h00000055, 0, 4'hF, 0, 0);
    do_xfer(1, 32'h30, 32'h00000077, 4, 4'hF, 2, 2);
    chk("t5_count", {16'b0, XFER_COUNT}, 32'd0);
    chk("t5_abort", {31'b0, ABORT_SEEN}, 32'd0);
    do_xfer(0, 32'h30, 32'h0, 0, 4'hF, 0, 0);
    chk("t5_mem", cap_prdata, 32'h00000055);
    chk("t5_count_after", {16'b0, XFER_COUNT}, 32'd1);

`ifdef APB4_PSTRB_EN
    do_xfer(1, 32'h40, 32'hFFFFFFFF, 0, 4'hF, 0, 0);
    do_xfer(1, 32'h40, 32'h00000000, 1, 4'b0101, 0, 0);
    do_xfer(1, 32'h40, 32'h12345678, 0, 4'b0000, 0, 0);
    chk("t6_nostrb_err", {31'b0, cap_pslverr}, 32'd0);
    do_xfer(0, 32'h40, 32'h0, 0, 4'hF, 0, 0);
    chk("t6_strb", cap_prdata, 32'hFF00FF00);
`endif

    // randomized transfers, mostly back-to-back
    for (int i = 0; i < 200; i++) begin
      int   sel, ws, mode, at;
      bit   wr;
      sel = $urandom_range(0, 9);
      if (sel < 7)       r_addr = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      else if (sel == 7) r_addr = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      else if (sel == 8) r_addr = 32'd1024 + 32'($urandom_range(0, 4095));
      else               r_addr = 32'd1020;
      wr   = (i < 20) ? 1'b1 : 1'($urandom_range(0, 1));
      ws   = $urandom_range(0, 3);
      mode = ($urandom_range(0, 9) == 0) ? 1 : 0;
      at   = $urandom_range(1, ws + 1);
      do_xfer(wr, r_addr, $urandom, ws, 4'($urandom), mode, at);
      if ($urandom_range(0, 3) == 0) begin
        bus.PSEL    = 1'($urandom_range(0, 1));
        bus.PENABLE = 1'b1;
        @(posedge clk); #1;
        bus_idle();
      end
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
